hash_iter_engine: RTL and testbench

//  Sequential, parametrised hash-iteration engine for the light DES-S-box hash. Streams message bytes in

---
 rtl/hash_pkg.sv | 42 ++++
 rtl/hash_round_chain.sv | 22 ++
 rtl/hash_iter_engine.sv | 122 ++++++++++++
 tb/tb_hash_iter_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared types and the S-box / Round step of the light DES-S-box hash.
// The S-box is DES S1 and the Round is a nibble rotation with S-box feedback.
package hash_pkg;

    typedef logic [7:0][3:0] h_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_e;

    // DES S1, addressed as {row[1:0], col[3:0]} with row = {x[5], x[0]} and col = x[4:1].
    localparam logic [3:0] SBOX_TABLE [64] = '{
        4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,
        4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
        4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,
        4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
        4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11,
        4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
        4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,
        4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13
    };

    function automatic logic [5:0] m6_of(input logic [7:0] m);
        return {m[5], m[7] ^ m[2], m[3], m[0], m[4] ^ m[1], m[6]};
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [5:0] x);
        return SBOX_TABLE[{x[5], x[0], x[4:1]}];
    endfunction

    // Nibbles shift up one place; the new nibble 0 mixes the outgoing nibble 7,
    // the S-box value and nibble 3 rotated left by one bit.
    function automatic h_state_t round_step(input logic [3:0] s, input h_state_t h);
        h_state_t r;
        r[7:1] = h[6:0];
        r[0]   = h[7] ^ s ^ {h[3][2:0], h[3][3]};
        return r;
    endfunction

endpackage

// File: rtl/hash_round_chain.sv
// N Round steps chained combinationally, all sharing one registered S-box value.
module hash_round_chain
    import hash_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [3:0] sbox_val,
    input  h_state_t   h_in,
    output h_state_t   h_out
);

    h_state_t stage [N+1];

    assign stage[0] = h_in;

    for (genvar g = 0; g < N; g++) begin : g_round
        assign stage[g+1] = round_step(sbox_val, stage[g]);
    end

    assign h_out = stage[N];

endmodule

// File: rtl/hash_iter_engine.sv
// Byte-streaming hash-iteration engine: ROUNDS Round steps per byte, ROUNDS_PER_CYCLE per clock.
// Optional feature macro HASH_ITER_CNT_EN adds the saturating byte_cnt output.
module hash_iter_engine
    import hash_pkg::*;
#(
    parameter int          ROUNDS           = 4,
    parameter int          ROUNDS_PER_CYCLE = 1,
    parameter logic [31:0] H_INIT           = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_first,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output h_state_t    out_digest,
    output logic        busy
`ifdef HASH_ITER_CNT_EN
    ,
    output logic [15:0] byte_cnt
`endif
);

    localparam int CNT_W = $clog2(ROUNDS + 1);

    if (ROUNDS < 1 || ROUNDS_PER_CYCLE < 1 ||
        (ROUNDS % ((ROUNDS_PER_CYCLE < 1) ? 1 : ROUNDS_PER_CYCLE)) != 0) begin : g_bad_params
        $error("hash_iter_engine: ROUNDS must be a positive multiple of ROUNDS_PER_CYCLE");
    end

    fsm_e             state_q, state_d;
    h_state_t         h_q, h_next;
    logic [3:0]       sbox_q;
    logic             last_q;
    logic [CNT_W-1:0] round_cnt_q;
    logic             accept;
    logic             run_end;

    assign accept  = in_valid && in_ready;
    assign run_end = (int'(round_cnt_q) + ROUNDS_PER_CYCLE) >= ROUNDS;

    hash_round_chain #(.N(ROUNDS_PER_CYCLE)) u_chain (
        .sbox_val (sbox_q),
        .h_in     (h_q),
        .h_out    (h_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_digest = '0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (run_end) state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                out_valid  = 1'b1;
                out_digest = h_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q         <= h_state_t'(H_INIT);
            sbox_q      <= '0;
            last_q      <= 1'b0;
            round_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sbox_q      <= sbox_lookup(m6_of(in_data));
                        last_q      <= in_last;
                        round_cnt_q <= '0;
                        if (in_first) h_q <= h_state_t'(H_INIT);
                    end
                end
                RUN: begin
                    h_q         <= h_next;
                    round_cnt_q <= round_cnt_q + CNT_W'(ROUNDS_PER_CYCLE);
                end
                DONE: begin
                    if (out_ready) h_q <= h_state_t'(H_INIT);
                end
                default: ;
            endcase
        end
    end

`ifdef HASH_ITER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (accept) begin
            if (in_first)                 byte_cnt <= 16'd1;
            else if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
        end else if (state_q == DONE && out_ready) begin
            byte_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_hash_iter_engine.sv
// Directed bench for hash_iter_engine; RPC selects the ROUNDS_PER_CYCLE build under test.
module tb_hash_iter_engine #(
    parameter int RPC = 1
);
    import hash_pkg::*;

    localparam int ROUNDS  = 4;
    localparam int RUN_CYC = ROUNDS / RPC;
    // Worked by hand: A5 -> M6 = 6'b100100 -> S1[row 2][col 2] = 4'hE; four Rounds from 0 give 0000EEEE.
    localparam logic [31:0] DIGEST_A5 = 32'h0000_EEEE;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_first, in_last;
    logic [7:0] in_data;
    logic       out_valid, out_ready, busy;
    h_state_t   out_digest;
`ifdef HASH_ITER_CNT_EN
    logic [15:0] byte_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hash_iter_engine #(
        .ROUNDS           (ROUNDS),
        .ROUNDS_PER_CYCLE (RPC),
        .H_INIT           (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_first   (in_first),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digest (out_digest),
        .busy       (busy)
`ifdef HASH_ITER_CNT_EN
        ,
        .byte_cnt   (byte_cnt)
`endif
    );

    // Reference model: DES S1 as a row/column table, state as a flat 32-bit word.
    int s1 [4][16] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
        '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
        '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
        '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
    };

    function automatic logic [31:0] ref_byte(input logic [31:0] h, input logic [7:0] m);
        logic [5:0] x;
        logic [3:0] s, n3;
        x[5] = m[5];
        x[4] = m[7] ^ m[2];
        x[3] = m[3];
        x[2] = m[0];
        x[1] = m[4] ^ m[1];
        x[0] = m[6];
        s = 4'(s1[{x[5], x[0]}][x[4:1]]);
        for (int r = 0; r < ROUNDS; r++) begin
            n3 = h[15:12];
            h  = {h[27:0], h[31:28] ^ s ^ {n3[2:0], n3[3]}};
        end
        return h;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic f, input logic l, output int acc_cyc);
        int n = 0;
        in_data  = d;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_budget", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic wait_digest(output int n, output int lows);
        n    = 0;
        lows = 0;
        while (!out_valid && n < 100) begin
            if (!in_ready) lows++;
            @(negedge clk);
            n++;
        end
        check("digest_in_budget", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic take_digest();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("take_out_valid", {31'b0, out_valid}, 32'd0);
        check("take_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int c0, c1, c2, n, lows;
        logic [31:0] exp_msg, held;

        // Reset held while a byte is offered: nothing may be accepted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_first  = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold_busy", {31'b0, busy}, 32'd0);
        check("rst_hold_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_digest", out_digest, 32'd0);
`ifdef HASH_ITER_CNT_EN
        check("reset_byte_cnt", {16'b0, byte_cnt}, 32'd0);
`endif

        // Single-byte message A5.
        send_byte(8'hA5, 1'b1, 1'b1, c0);
        in_valid = 1'b0;
        wait_digest(n, lows);
        check("single_latency", n, RUN_CYC);
        check("single_ready_low", lows, RUN_CYC);
        check("single_digest", out_digest, DIGEST_A5);
        check("single_digest_model", out_digest, ref_byte(32'h0, 8'hA5));
        take_digest();

        // Three-byte message with in_valid held high between bytes.
        exp_msg = ref_byte(ref_byte(ref_byte(32'h0, 8'h00), 8'hFF), 8'h3C);
        send_byte(8'h00, 1'b1, 1'b0, c0);
        send_byte(8'hFF, 1'b0, 1'b0, c1);
        send_byte(8'h3C, 1'b0, 1'b1, c2);
        in_valid = 1'b0;
        check("msg3_spacing_1", c1 - c0, RUN_CYC + 1);
        check("msg3_spacing_2", c2 - c1, RUN_CYC + 1);
        wait_digest(n, lows);
        check("msg3_digest", out_digest, exp_msg);
`ifdef HASH_ITER_CNT_EN
        check("msg3_byte_cnt", {16'b0, byte_cnt}, 32'd3);
`endif

        // Back-pressure in DONE: digest held, input blocked.
        held = out_digest;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_digest", out_digest, held);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        check("hold_out_valid", {31'b0, out_valid}, 32'd1);
        take_digest();
`ifdef HASH_ITER_CNT_EN
        check("taken_byte_cnt", {16'b0, byte_cnt}, 32'd0);
`endif

        // Byte without in_first after a digest chains from H_INIT.
        send_byte(8'hA5, 1'b0, 1'b1, c0);
        in_valid = 1'b0;
        wait_digest(n, lows);
        check("after_take_digest", out_digest, DIGEST_A5);
        take_digest();

        // in_first inside an open message restarts it.
        send_byte(8'h11, 1'b1, 1'b0, c0);
        send_byte(8'h22, 1'b0, 1'b0, c1);
        send_byte(8'hA5, 1'b1, 1'b1, c2);
        in_valid = 1'b0;
        wait_digest(n, lows);
        check("restart_digest", out_digest, DIGEST_A5);
`ifdef HASH_ITER_CNT_EN
        check("restart_byte_cnt", {16'b0, byte_cnt}, 32'd1);
`endif
        take_digest();

        // Reset pulsed while byte 2 of a message is in its rounds.
        send_byte(8'h11, 1'b1, 1'b0, c0);
        send_byte(8'h22, 1'b0, 1'b0, c1);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_run_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_busy", {31'b0, busy}, 32'd0);
        check("rst_run_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_run_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef HASH_ITER_CNT_EN
        check("rst_run_byte_cnt", {16'b0, byte_cnt}, 32'd0);
`endif
        send_byte(8'hA5, 1'b1, 1'b1, c0);
        in_valid = 1'b0;
        wait_digest(n, lows);
        check("post_rst_latency", n, RUN_CYC);
        check("post_rst_digest", out_digest, DIGEST_A5);
        take_digest();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
